// File: rtl/rot_period_monitor_if.sv
// rot_period_monitor_if: word stream in, period/checksum status out for the period monitor.
interface rot_period_monitor_if #(
  parameter int W = 8,
  parameter int CNT_W = 16
);
  logic [W-1:0] __in0;
  logic en;
  logic clear;
  logic [CNT_W-1:0] period;
  logic period_valid;
  logic [W-1:0] checksum;
  logic mismatch;
  logic overflow;
  logic [1:0] state;
  modport master (
    output __in0, en, clear,
    input period, period_valid, checksum, mismatch, overflow, state
  );
  modport slave (
    input __in0, en, clear,
    output period, period_valid, checksum, mismatch, overflow, state
  );
endinterface

// File: rtl/rot_period_monitor.sv
// rot_period_monitor: locks onto the first word, measures its recurrence period and per-period XOR checksum.
module rot_period_monitor #(
  parameter int W = 8,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  rot_period_monitor_if.slave m
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, LOCKED = 2'd2, OVF = 2'd3} state_t;
  localparam logic [CNT_W-1:0] MAX_CNT = '1;
  state_t state_q, state_d;
  logic [W-1:0] ref_q, ref_d, acc_q, acc_d, checksum_q, checksum_d;
  logic [CNT_W-1:0] count_q, count_d, period_q, period_d;
  logic period_valid_q, period_valid_d, mismatch_q, mismatch_d, overflow_q, overflow_d;
  logic [W-1:0] w;
  assign w = m.__in0;
  always_comb begin
    state_d = state_q;
    ref_d = ref_q;
    acc_d = acc_q;
    checksum_d = checksum_q;
    count_d = count_q;
    period_d = period_q;
    period_valid_d = period_valid_q;
    mismatch_d = mismatch_q;
    overflow_d = overflow_q;
    if (m.clear) begin
      state_d = IDLE;
      ref_d = '0;
      acc_d = '0;
      checksum_d = '0;
      count_d = '0;
      period_d = '0;
      period_valid_d = 1'b0;
      mismatch_d = 1'b0;
      overflow_d = 1'b0;
    end else if (m.en) begin
      case (state_q)
        IDLE: begin
          ref_d = w;
          count_d = CNT_W'(1);
          acc_d = w;
          state_d = ARMED;
        end
        ARMED, LOCKED: begin
          if (w == ref_q) begin
            if (state_q == ARMED) begin
              period_d = count_q;
              period_valid_d = 1'b1;
              state_d = LOCKED;
            end else if (count_q != period_q) begin
              mismatch_d = 1'b1;
            end
            checksum_d = acc_q;
            count_d = CNT_W'(1);
            acc_d = w;
          end else if (count_q == MAX_CNT) begin
            state_d = OVF;
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
            acc_d = acc_q ^ w;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ref_q <= '0;
      acc_q <= '0;
      checksum_q <= '0;
      count_q <= '0;
      period_q <= '0;
      period_valid_q <= 1'b0;
      mismatch_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q <= ref_d;
      acc_q <= acc_d;
      checksum_q <= checksum_d;
      count_q <= count_d;
      period_q <= period_d;
      period_valid_q <= period_valid_d;
      mismatch_q <= mismatch_d;
      overflow_q <= overflow_d;
    end
  end
  assign m.period = period_q;
  assign m.period_valid = period_valid_q;
  assign m.checksum = checksum_q;
  assign m.mismatch = mismatch_q;
  assign m.overflow = overflow_q;
  assign m.state = state_q;
endmodule

// File: tb/tb_rot_period_monitor.sv
// tb_rot_period_monitor: random and directed streams into 16-bit and 4-bit counter instances vs. a history-based model.
module tb_rot_period_monitor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  rot_period_monitor_if #(.W(8), .CNT_W(16)) a_if ();
  rot_period_monitor_if #(.W(8), .CNT_W(4)) b_if ();
  rot_period_monitor #(.W(8), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .m(a_if.slave));
  rot_period_monitor #(.W(8), .CNT_W(4)) dut_b (.clk(clk), .rst(rst), .m(b_if.slave));
  typedef struct packed {
    logic [1:0] st;
    logic [15:0] per;
    logic pv;
    logic [7:0] cs;
    logic mm;
    logic ov;
  } exp_t;
  int total = 0;
  int bad = 0;
  logic [7:0] ha[$];
  logic [7:0] hb[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Outputs derived from the whole accepted history since the last restart.
  function automatic exp_t model(input logic [7:0] h[$], input int maxc);
    exp_t e;
    int last;
    logic [7:0] x;
    e = '0;
    last = 0;
    if (h.size() == 0) return e;
    e.st = 2'd1;
    for (int i = 1; i < h.size(); i++) begin
      if (h[i] == h[0]) begin
        x = 8'h00;
        for (int j = last; j < i; j++) x ^= h[j];
        if (!e.pv) begin
          e.per = 16'(i - last);
          e.pv = 1'b1;
          e.st = 2'd2;
        end else if ((i - last) != int'(e.per)) begin
          e.mm = 1'b1;
        end
        e.cs = x;
        last = i;
      end else if (i - last == maxc) begin
        e.ov = 1'b1;
        e.st = 2'd3;
      end
    end
    return e;
  endfunction
  task automatic step(input logic [7:0] w, input logic e, input logic c, input logic r);
    exp_t ea, eb;
    a_if.__in0 = w;
    b_if.__in0 = w;
    a_if.en = e;
    b_if.en = e;
    a_if.clear = c;
    b_if.clear = c;
    rst = r;
    @(posedge clk);
    #1;
    if (r || c) begin
      ha.delete();
      hb.delete();
    end else if (e) begin
      if (!model(ha, 65535).ov) ha.push_back(w);
      if (!model(hb, 15).ov) hb.push_back(w);
    end
    ea = model(ha, 65535);
    eb = model(hb, 15);
    chk("a_state", 32'(a_if.state), 32'(ea.st));
    chk("a_period", 32'(a_if.period), 32'(ea.per));
    chk("a_period_valid", 32'(a_if.period_valid), 32'(ea.pv));
    chk("a_checksum", 32'(a_if.checksum), 32'(ea.cs));
    chk("a_mismatch", 32'(a_if.mismatch), 32'(ea.mm));
    chk("a_overflow", 32'(a_if.overflow), 32'(ea.ov));
    chk("b_state", 32'(b_if.state), 32'(eb.st));
    chk("b_period", 32'(b_if.period), 32'(eb.per));
    chk("b_period_valid", 32'(b_if.period_valid), 32'(eb.pv));
    chk("b_checksum", 32'(b_if.checksum), 32'(eb.cs));
    chk("b_mismatch", 32'(b_if.mismatch), 32'(eb.mm));
    chk("b_overflow", 32'(b_if.overflow), 32'(eb.ov));
  endtask
  task automatic word(input logic [7:0] w);
    step(w, 1'b1, 1'b0, 1'b0);
  endtask
  initial begin
    logic [7:0] w;
    int mode;
    step(8'h00, 1'b0, 1'b0, 1'b1);
    step(8'h00, 1'b1, 1'b0, 1'b1);
    chk("reset_state", 32'(a_if.state), 32'd0);
    word(8'h11); word(8'h22); word(8'h44); word(8'h11);
    chk("tp1_state", 32'(a_if.state), 32'd2);
    chk("tp1_period", 32'(a_if.period), 32'd3);
    chk("tp1_checksum", 32'(a_if.checksum), 32'h77);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) word(8'h5A);
    chk("const_period", 32'(a_if.period), 32'd1);
    chk("const_checksum", 32'(a_if.checksum), 32'h5A);
    chk("const_mismatch", 32'(a_if.mismatch), 32'd0);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    word(8'h11); word(8'h22); word(8'h11); word(8'h33); word(8'h44); word(8'h11);
    chk("mm_flag", 32'(a_if.mismatch), 32'd1);
    chk("mm_checksum", 32'(a_if.checksum), 32'h66);
    chk("mm_period", 32'(a_if.period), 32'd2);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) word(8'(i));
    chk("ovf_state", 32'(b_if.state), 32'd3);
    chk("ovf_flag", 32'(b_if.overflow), 32'd1);
    word(8'h00);
    chk("ovf_absorb", 32'(b_if.state), 32'd3);
    step(8'h00, 1'b0, 1'b1, 1'b0);
    chk("ovf_clear", 32'(b_if.state), 32'd0);
    word(8'h11);
    step(8'h11, 1'b0, 1'b0, 1'b0);
    word(8'h22); word(8'h11);
    chk("gate_period", 32'(a_if.period), 32'd2);
    chk("gate_checksum", 32'(a_if.checksum), 32'h33);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) word(8'(i));
    step(8'h01, 1'b1, 1'b0, 1'b1);
    chk("mid_rst_state", 32'(a_if.state), 32'd0);
    word(8'h07); word(8'h01); word(8'h07);
    chk("mid_rst_period", 32'(a_if.period), 32'd2);
    step(8'h09, 1'b1, 1'b1, 1'b1);
    mode = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) mode = $urandom_range(0, 2);
      w = (mode == 0) ? 8'($urandom_range(0, 3)) : (mode == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      step(w, $urandom_range(0, 7) != 0, $urandom_range(0, 59) == 0, $urandom_range(0, 149) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
